// File: rtl/aes_shift_rows_ser_pkg.sv
// Shared types and constants for the serial AES ShiftRows wrapper.
package aes_shift_rows_ser_pkg;

  localparam int COL_W  = 32;
  localparam int N_COLS = 4;

  typedef enum logic {
    LOAD  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  typedef enum logic {
    FWD = 1'b0,
    INV = 1'b1
  } op_e;

  // AES state indexed [row][col][bit]
  typedef logic [N_COLS-1:0][N_COLS-1:0][7:0] state_arr_t;

endpackage

// File: rtl/aes_shift_rows.sv
// Combinational AES ShiftRows / InvShiftRows on a full 4x4 byte state.
module aes_shift_rows
  import aes_shift_rows_ser_pkg::*;
(
  input  logic [N_COLS-1:0][N_COLS-1:0][7:0] state_i,
  input  logic                               op_i,
  output logic [N_COLS-1:0][N_COLS-1:0][7:0] state_o
);

  // Row r rotates left by r (forward) or right by r (inverse); 2-bit truncation gives mod 4.
  always_comb begin
    state_o = '0;
    for (int r = 0; r < N_COLS; r++) begin
      for (int c = 0; c < N_COLS; c++) begin
        if (op_e'(op_i) == INV) begin
          state_o[2'(r)][2'(c)] = state_i[2'(r)][2'(c - r)];
        end else begin
          state_o[2'(r)][2'(c)] = state_i[2'(r)][2'(c + r)];
        end
      end
    end
  end

endmodule

// File: rtl/aes_shift_rows_ser.sv
// Serial column-at-a-time wrapper around aes_shift_rows: load 4 columns, then drain 4.
// Optional synchronous flush input enabled by defining AES_SHIFT_ROWS_SER_FLUSH_EN.
module aes_shift_rows_ser
  import aes_shift_rows_ser_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
`ifdef AES_SHIFT_ROWS_SER_FLUSH_EN
  input  logic             flush_i,
`endif
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [COL_W-1:0] in_data_i,
  input  logic             op_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [COL_W-1:0] out_data_o
);

  state_e     state_q, state_d, state_hs_s;
  logic [1:0] cnt_q, cnt_d, cnt_hs_s;
  logic       op_q, op_d, op_hs_s;
  state_arr_t buf_q, buf_d, buf_hs_s;
  state_arr_t shifted_s;

  assign in_ready_o  = (state_q == LOAD);
  assign out_valid_o = (state_q == DRAIN);

  // Handshake-driven next state: fill columns in LOAD, step through columns in DRAIN.
  always_comb begin
    state_hs_s = state_q;
    cnt_hs_s   = cnt_q;
    op_hs_s    = op_q;
    buf_hs_s   = buf_q;
    case (state_q)
      LOAD: begin
        if (in_valid_i) begin
          for (int r = 0; r < N_COLS; r++) begin
            buf_hs_s[2'(r)][cnt_q] = in_data_i[8*r +: 8];
          end
          if (cnt_q == 2'd0) begin
            op_hs_s = op_i;
          end else begin
            op_hs_s = op_q;
          end
          if (cnt_q == 2'd3) begin
            state_hs_s = DRAIN;
            cnt_hs_s   = 2'd0;
          end else begin
            cnt_hs_s   = cnt_q + 2'd1;
          end
        end else begin
          cnt_hs_s = cnt_q;
        end
      end
      DRAIN: begin
        if (out_ready_i) begin
          if (cnt_q == 2'd3) begin
            state_hs_s = LOAD;
            cnt_hs_s   = 2'd0;
          end else begin
            cnt_hs_s   = cnt_q + 2'd1;
          end
        end else begin
          cnt_hs_s = cnt_q;
        end
      end
      default: begin
        state_hs_s = LOAD;
        cnt_hs_s   = 2'd0;
      end
    endcase
  end

`ifdef AES_SHIFT_ROWS_SER_FLUSH_EN
  // Flush wins over any handshake in the same cycle.
  always_comb begin
    if (flush_i) begin
      state_d = LOAD;
      cnt_d   = 2'd0;
      op_d    = 1'b0;
      buf_d   = '0;
    end else begin
      state_d = state_hs_s;
      cnt_d   = cnt_hs_s;
      op_d    = op_hs_s;
      buf_d   = buf_hs_s;
    end
  end
`else
  // No flush: next state comes straight from the handshake logic.
  always_comb begin
    state_d = state_hs_s;
    cnt_d   = cnt_hs_s;
    op_d    = op_hs_s;
    buf_d   = buf_hs_s;
  end
`endif

  // State, counter, latched op and column buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      cnt_q   <= 2'd0;
      op_q    <= 1'b0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      buf_q   <= buf_d;
    end
  end

  aes_shift_rows u_rows (
    .state_i (buf_q),
    .op_i    (op_q),
    .state_o (shifted_s)
  );

  // Output column cnt of the permuted state, zero outside DRAIN.
  always_comb begin
    out_data_o = '0;
    if (state_q == DRAIN) begin
      for (int r = 0; r < N_COLS; r++) begin
        out_data_o[8*r +: 8] = shifted_s[2'(r)][cnt_q];
      end
    end else begin
      out_data_o = '0;
    end
  end

endmodule

// File: tb/tb_aes_shift_rows_ser.sv
// Randomised self-checking bench for aes_shift_rows_ser against a byte-matrix reference model.
module tb_aes_shift_rows_ser;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
`ifdef AES_SHIFT_ROWS_SER_FLUSH_EN
  logic        flush;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  logic [7:0] m_in [4][4];
  logic       m_op;

  always #5 clk = ~clk;

  aes_shift_rows_ser dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef AES_SHIFT_ROWS_SER_FLUSH_EN
    .flush_i     (flush),
`endif
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .op_i        (op),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data)
  );

  function automatic logic [31:0] tv_word(input int c);
    logic [31:0] w;
    for (int r = 0; r < 4; r++) w[8*r +: 8] = 8'(16 * r + c);
    return w;
  endfunction

  function automatic logic [31:0] model_col(input int c);
    logic [31:0] w;
    int src;
    for (int r = 0; r < 4; r++) begin
      src = m_op ? ((c - r + 4) % 4) : ((c + r) % 4);
      w[8*r +: 8] = m_in[r][src];
    end
    return w;
  endfunction

  task automatic model_store(input logic [31:0] w, input int c);
    for (int r = 0; r < 4; r++) m_in[r][c] = w[8*r +: 8];
  endtask

  // Called at a negedge; returns at the negedge after the beat was accepted.
  task automatic put_col(input logic [31:0] d, input logic o, input int idle);
    int wait_n;
    in_valid = 1'b0;
    repeat (idle) @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    op       = o;
    wait_n   = 0;
    while (!in_ready && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fails++;
      $display("FAIL put_col_timeout: in_ready=%b required 1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = $urandom;
    op       = 1'($urandom);
  endtask

  task automatic get_col(output logic [31:0] d, input int stall);
    int wait_n;
    out_ready = 1'b0;
    repeat (stall) @(negedge clk);
    out_ready = 1'b1;
    wait_n    = 0;
    while (!out_valid && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    if (!out_valid) begin
      n_checks++;
      n_fails++;
      $display("FAIL get_col_timeout: out_valid=%b required 1", out_valid);
    end
    d = out_data;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'h0) begin
      n_fails++;
      $display("FAIL reset_state: rdy=%b vld=%b data=%h required 1 0 00000000",
               in_ready, out_valid, out_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_forward;
    logic [31:0] d;
    m_op = 1'b0;
    for (int c = 0; c < 4; c++) begin
      put_col(tv_word(c), 1'b0, 0);
      model_store(tv_word(c), c);
      n_checks++;
      if (out_valid !== (c == 3)) begin
        n_fails++;
        $display("FAIL fwd_latency beat%0d: out_valid=%b required %b", c, out_valid, c == 3);
      end
    end
    for (int c = 0; c < 4; c++) begin
      get_col(d, 0);
      n_checks++;
      if (d !== model_col(c)) begin
        n_fails++;
        $display("FAIL fwd_col%0d: got %h required %h", c, d, model_col(c));
      end
      if (c == 0) begin
        n_checks++;
        if (d !== 32'h33221100) begin
          n_fails++;
          $display("FAIL fwd_col0_const: got %h required 33221100", d);
        end
      end
      if (c == 1) begin
        n_checks++;
        if (d !== 32'h30231201) begin
          n_fails++;
          $display("FAIL fwd_col1_const: got %h required 30231201", d);
        end
      end
    end
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fails++;
      $display("FAIL fwd_reload_ready: rdy=%b vld=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic run_block_tv(input logic op0, input logic opn, input logic [31:0] col0_exp,
                              input string name);
    logic [31:0] d;
    m_op = op0;
    for (int c = 0; c < 4; c++) begin
      put_col(tv_word(c), (c == 0) ? op0 : opn, 0);
      model_store(tv_word(c), c);
    end
    for (int c = 0; c < 4; c++) begin
      get_col(d, 0);
      n_checks++;
      if (d !== model_col(c)) begin
        n_fails++;
        $display("FAIL %s_col%0d: got %h required %h", name, c, d, model_col(c));
      end
      if (c == 0) begin
        n_checks++;
        if (d !== col0_exp) begin
          n_fails++;
          $display("FAIL %s_col0_const: got %h required %h", name, d, col0_exp);
        end
      end
    end
  endtask

  task automatic test_inverse;
    run_block_tv(1'b1, 1'b1, 32'h31221300, "inv");
  endtask

  task automatic test_op_toggle;
    run_block_tv(1'b1, 1'b0, 32'h31221300, "optoggle");
  endtask

  task automatic test_backpressure;
    logic [31:0] d;
    m_op = 1'b0;
    for (int c = 0; c < 4; c++) begin
      put_col(tv_word(c), 1'b0, 0);
      model_store(tv_word(c), c);
    end
    get_col(d, 0);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (out_data !== 32'h30231201 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_fails++;
        $display("FAIL bp_hold%0d: data=%h vld=%b rdy=%b required 30231201 1 0",
                 i, out_data, out_valid, in_ready);
      end
      @(negedge clk);
    end
    for (int c = 1; c < 4; c++) begin
      get_col(d, 0);
      n_checks++;
      if (d !== model_col(c)) begin
        n_fails++;
        $display("FAIL bp_col%0d: got %h required %h", c, d, model_col(c));
      end
    end
  endtask

  task automatic test_reset_mid_block;
    for (int c = 0; c < 3; c++) put_col($urandom, 1'b1, 0);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'h0) begin
      n_fails++;
      $display("FAIL midrst_state: rdy=%b vld=%b data=%h required 1 0 00000000",
               in_ready, out_valid, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_block_tv(1'b0, 1'b0, 32'h33221100, "midrst");
  endtask

  task automatic test_drain_ignores_input;
    logic [31:0] d;
    logic [31:0] w;
    m_op = 1'($urandom);
    for (int c = 0; c < 4; c++) begin
      w = $urandom;
      put_col(w, (c == 0) ? m_op : 1'($urandom), 0);
      model_store(w, c);
    end
    in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      in_data = $urandom;
      op      = 1'($urandom);
      get_col(d, 1);
      if (c == 3) in_valid = 1'b0;
      n_checks++;
      if (d !== model_col(c)) begin
        n_fails++;
        $display("FAIL drain_in_col%0d: got %h required %h", c, d, model_col(c));
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] d;
    logic [31:0] w;
    for (int b = 0; b < 8; b++) begin
      m_op = 1'($urandom);
      for (int c = 0; c < 4; c++) begin
        w = $urandom;
        put_col(w, (c == 0) ? m_op : 1'($urandom), $urandom_range(0, 2));
        model_store(w, c);
      end
      for (int c = 0; c < 4; c++) begin
        get_col(d, $urandom_range(0, 2));
        n_checks++;
        if (d !== model_col(c)) begin
          n_fails++;
          $display("FAIL rand_b%0d_col%0d: got %h required %h", b, c, d, model_col(c));
        end
      end
    end
  endtask

`ifdef AES_SHIFT_ROWS_SER_FLUSH_EN
  task automatic test_flush;
    logic [31:0] d;
    for (int c = 0; c < 4; c++) put_col(tv_word(c), 1'b1, 0);
    get_col(d, 0);
    get_col(d, 0);
    out_ready = 1'b1;
    flush     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush     = 1'b0;
    out_ready = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'h0) begin
      n_fails++;
      $display("FAIL flush_state: rdy=%b vld=%b data=%h required 1 0 00000000",
               in_ready, out_valid, out_data);
    end
    run_block_tv(1'b0, 1'b1, 32'h33221100, "postflush");
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    op        = 1'b0;
    out_ready = 1'b0;
`ifdef AES_SHIFT_ROWS_SER_FLUSH_EN
    flush     = 1'b0;
`endif
    repeat (2) @(negedge clk);
    test_reset();
    test_forward();
    test_inverse();
    test_backpressure();
    test_reset_mid_block();
    test_op_toggle();
    test_drain_ignores_input();
    test_random();
`ifdef AES_SHIFT_ROWS_SER_FLUSH_EN
    test_flush();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
